alu_exec_unit: RTL

//  Execution-side receiver for one Unified Issue Queue issue slot. Accepts an issued op, computes
//  its result in a 2-stage pipe, returns it to the ROB through a valid/ready writeback port.

---
 rtl/alu_exec_unit_pkg.sv | 39 +++
 rtl/alu_exec_unit_if.sv | 38 +++
 rtl/alu_exec_unit_result_fifo.sv | 69 ++++++
 rtl/alu_exec_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared execution-unit definitions: op encodings (common with the UIQ), datapath widths and
// the writeback entry layout carried through the result FIFO.
package alu_exec_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned PREG_W   = 6;
  localparam int unsigned ROB_W    = 6;
  localparam int unsigned OPTYPE_W = 4;
  localparam int unsigned ALUNUM_W = 2;

  // Op encodings as issued by the UIQ
  localparam logic [OPTYPE_W-1:0] OpAdd  = 4'd1;
  localparam logic [OPTYPE_W-1:0] OpAddi = 4'd2;
  localparam logic [OPTYPE_W-1:0] OpLui  = 4'd3;
  localparam logic [OPTYPE_W-1:0] OpOri  = 4'd4;
  localparam logic [OPTYPE_W-1:0] OpXor  = 4'd5;
  localparam logic [OPTYPE_W-1:0] OpSrai = 4'd6;
  localparam logic [OPTYPE_W-1:0] OpLb   = 4'd7;
  localparam logic [OPTYPE_W-1:0] OpLw   = 4'd8;
  localparam logic [OPTYPE_W-1:0] OpSb   = 4'd9;
  localparam logic [OPTYPE_W-1:0] OpSw   = 4'd10;

  // Result FIFO payload, ordered {illegal, PC, ROBNum, destReg, data}
  typedef struct packed {
    logic              illegal;
    logic [XLEN-1:0]   pc;
    logic [ROB_W-1:0]  rob;
    logic [PREG_W-1:0] dest;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  localparam int unsigned WbEntryW = $bits(wb_entry_t);

  // Loads and stores only need their effective address from this unit
  function automatic logic is_mem_op(input logic [OPTYPE_W-1:0] op);
    return (op == OpLb) || (op == OpLw) || (op == OpSb) || (op == OpSw);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue and writeback bundle of one ALU issue slot. master = UIQ/ROB side, slave = exec unit.
interface alu_exec_unit_if;
  import alu_exec_unit_pkg::*;

  logic                issue_valid_in;
  logic [XLEN-1:0]     PC_in;
  logic [OPTYPE_W-1:0] optype_in;
  logic [ALUNUM_W-1:0] aluNum_in;
  logic [XLEN-1:0]     srcReg1_data_in;
  logic [XLEN-1:0]     srcReg2_data_in;
  logic [XLEN-1:0]     imm_in;
  logic [PREG_W-1:0]   destReg_in;
  logic [ROB_W-1:0]    ROBNum_in;
  logic                fu_ready_out;

  logic                wb_valid_out;
  logic                wb_ready_in;
  logic [XLEN-1:0]     wb_data_out;
  logic [PREG_W-1:0]   wb_destReg_out;
  logic [ROB_W-1:0]    wb_ROBNum_out;
  logic [XLEN-1:0]     wb_PC_out;
  logic                wb_illegal_out;

  modport master (
    output issue_valid_in, PC_in, optype_in, aluNum_in, srcReg1_data_in, srcReg2_data_in,
           imm_in, destReg_in, ROBNum_in, wb_ready_in,
    input  fu_ready_out, wb_valid_out, wb_data_out, wb_destReg_out, wb_ROBNum_out, wb_PC_out,
           wb_illegal_out
  );

  modport slave (
    input  issue_valid_in, PC_in, optype_in, aluNum_in, srcReg1_data_in, srcReg2_data_in,
           imm_in, destReg_in, ROBNum_in, wb_ready_in,
    output fu_ready_out, wb_valid_out, wb_data_out, wb_destReg_out, wb_ROBNum_out, wb_PC_out,
           wb_illegal_out
  );

endinterface

// File: rtl/alu_exec_unit_result_fifo.sv
// Synchronous result FIFO with explicit pointer wrap (Depth need not be a power of two).
// Simultaneous push and pop keeps occupancy unchanged.
module alu_exec_unit_result_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // Upstream credits keep a full FIFO from being pushed; the guard only protects storage
  assign do_push = push_i & (count_q != CntW'(Depth));
  assign rdata_o = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while the entry is not occupied
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit behind one UIQ issue slot: S1 operand latch, result mux, result FIFO and
// credit counter driving fu_ready_out. Fixed issue-to-writeback latency of two cycles.
// Optional feature: define EXEC_AGU_EN to execute LB/LW/SB/SW as address generation (s1+imm);
// otherwise they complete as illegal with zero data.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned         RES_DEPTH = 2,
  parameter logic [ALUNUM_W-1:0] FU_ID     = '0
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_unit_if.slave io
);

  localparam int unsigned CntW = $clog2(RES_DEPTH + 1);

  logic                accept;
  logic                pop;
  logic                fifo_empty;
  wb_entry_t           result;
  wb_entry_t           head;
  logic [WbEntryW-1:0] head_raw;

  logic                s1_valid_q, s1_valid_d;
  logic [OPTYPE_W-1:0] s1_op_q,    s1_op_d;
  logic [XLEN-1:0]     s1_a_q,     s1_a_d;
  logic [XLEN-1:0]     s1_b_q,     s1_b_d;
  logic [XLEN-1:0]     s1_imm_q,   s1_imm_d;
  logic [XLEN-1:0]     s1_pc_q,    s1_pc_d;
  logic [PREG_W-1:0]   s1_dest_q,  s1_dest_d;
  logic [ROB_W-1:0]    s1_rob_q,   s1_rob_d;

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                fu_ready_q, fu_ready_d;

  assign accept = io.issue_valid_in & fu_ready_q & (io.aluNum_in == FU_ID);
  assign pop    = ~fifo_empty & io.wb_ready_in;

  // S1 capture: operands load only on an accepted issue, valid tracks accept every cycle
  always_comb begin
    s1_valid_d = accept;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_imm_d   = s1_imm_q;
    s1_pc_d    = s1_pc_q;
    s1_dest_d  = s1_dest_q;
    s1_rob_d   = s1_rob_q;
    if (accept) begin
      s1_op_d   = io.optype_in;
      s1_a_d    = io.srcReg1_data_in;
      s1_b_d    = io.srcReg2_data_in;
      s1_imm_d  = io.imm_in;
      s1_pc_d   = io.PC_in;
      s1_dest_d = io.destReg_in;
      s1_rob_d  = io.ROBNum_in;
    end
  end

  // S1 register; reset discards any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_imm_q   <= '0;
      s1_pc_q    <= '0;
      s1_dest_q  <= '0;
      s1_rob_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_imm_q   <= s1_imm_d;
      s1_pc_q    <= s1_pc_d;
      s1_dest_q  <= s1_dest_d;
      s1_rob_q   <= s1_rob_d;
    end
  end

  // Result mux over the S1 operands
  always_comb begin
    result         = '0;
    result.pc      = s1_pc_q;
    result.rob     = s1_rob_q;
    result.dest    = s1_dest_q;
    result.illegal = 1'b0;
    case (s1_op_q)
      OpAdd:   result.data = s1_a_q + s1_b_q;
      OpAddi:  result.data = s1_a_q + s1_imm_q;
      OpLui:   result.data = s1_imm_q;
      OpOri:   result.data = s1_a_q | s1_imm_q;
      OpXor:   result.data = s1_a_q ^ s1_b_q;
      OpSrai:  result.data = XLEN'($signed(s1_a_q) >>> s1_imm_q[4:0]);
      default: begin
`ifdef EXEC_AGU_EN
        if (is_mem_op(s1_op_q)) begin
          result.data = s1_a_q + s1_imm_q;
        end else begin
          result.illegal = 1'b1;
        end
`else
        result.illegal = 1'b1;
`endif
      end
    endcase
  end

  alu_exec_unit_result_fifo #(
    .Depth (RES_DEPTH),
    .Width (WbEntryW)
  ) u_result_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (s1_valid_q),
    .wdata_i (result),
    .pop_i   (pop),
    .rdata_o (head_raw),
    .empty_o (fifo_empty)
  );

  assign head = wb_entry_t'(head_raw);

  // Credits: S1 occupancy plus FIFO occupancy; ready is registered from the next count
  always_comb begin
    cnt_d      = cnt_q + CntW'(accept) - CntW'(pop);
    fu_ready_d = (cnt_d < CntW'(RES_DEPTH));
  end

  // Credit counter and ready flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      fu_ready_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      fu_ready_q <= fu_ready_d;
    end
  end

  // Writeback outputs are forced to zero whenever no entry is presented
  always_comb begin
    io.fu_ready_out   = fu_ready_q;
    io.wb_valid_out   = ~fifo_empty;
    io.wb_data_out    = '0;
    io.wb_destReg_out = '0;
    io.wb_ROBNum_out  = '0;
    io.wb_PC_out      = '0;
    io.wb_illegal_out = 1'b0;
    if (!fifo_empty) begin
      io.wb_data_out    = head.data;
      io.wb_destReg_out = head.dest;
      io.wb_ROBNum_out  = head.rob;
      io.wb_PC_out      = head.pc;
      io.wb_illegal_out = head.illegal;
    end
  end

endmodule
